// File: rtl/lifo_rd_pkg.sv
// Shared types for the LIFO burst reader.
// Holds the FSM state encoding and the skid buffer entry layout.
package lifo_rd_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      POP,
      DRAIN,
      DONE
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sop;
      logic              eop;
   } skid_entry_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry valid/ready buffer with fall-through.
// An incoming word is presented at once when the buffer is empty.
module stream_skid2 #(
   parameter int W = 10
) (
   input  logic         clk_i,
   input  logic         srst_n_i,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] dout_o,
   output logic [1:0]   occ_o
);

   logic [W-1:0] e0;
   logic [W-1:0] e1;
   logic [1:0]   occ;
   logic         take;

   assign valid_o = (occ != 2'd0) || push_i;
   assign dout_o  = (occ != 2'd0) ? e0 : (push_i ? din_i : '0);
   assign take    = valid_o && ready_i;
   assign occ_o   = occ;

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         occ <= 2'd0;
         e0  <= '0;
         e1  <= '0;
      end else begin
         unique case (occ)
            2'd0: begin
               if (push_i && !take) begin
                  e0  <= din_i;
                  occ <= 2'd1;
               end
            end
            2'd1: begin
               if (push_i && take) begin
                  e0 <= din_i;
               end else if (push_i) begin
                  e1  <= din_i;
                  occ <= 2'd2;
               end else if (take) begin
                  occ <= 2'd0;
               end
            end
            default: begin
               if (take) begin
                  e0 <= e1;
                  if (push_i) e1 <= din_i;
                  else occ <= 2'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/lifo_burst_reader.sv
// Pops a burst from the LIFO and re-emits it as a sop/eop framed stream.
// Hides the registered read latency and the stale empty/usedw flags.
module lifo_burst_reader
   import lifo_rd_pkg::*;
#(
   parameter int DWIDTH     = DATA_W,
   parameter int AWIDTH_EXP = 3,
   parameter int BLEN_W     = 4
) (
   input  logic                  clk_i,
   input  logic                  srst_n_i,
   input  logic                  start_i,
   input  logic [BLEN_W-1:0]     burst_len_i,
   input  logic                  abort_i,
   input  logic                  lifo_empty_i,
   input  logic                  lifo_full_i,
   input  logic [AWIDTH_EXP-1:0] lifo_usedw_i,
   input  logic                  lifo_wrreq_i,
   input  logic [DWIDTH-1:0]     lifo_q_i,
   output logic                  lifo_rdreq_o,
   output logic [DWIDTH-1:0]     data_o,
   output logic                  valid_o,
   output logic                  sop_o,
   output logic                  eop_o,
   input  logic                  ready_i,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int CW = AWIDTH_EXP + 1;
   localparam int EW = $bits(skid_entry_t);

   state_t            state;
   logic [BLEN_W-1:0] remaining;
   logic              pop;
   logic              pop_d1;
   logic              sop_d1;
   logic              eop_d1;
   logic              first_pop;
   logic              aborted;
   logic [CW-1:0]     cnt;
   logic [2:0]        inflight;
   logic [1:0]        occ;
   skid_entry_t       cap;
   skid_entry_t       head;
   logic [EW-1:0]     head_w;

   assign cnt = lifo_full_i ? {1'b1, {AWIDTH_EXP{1'b0}}}
                            : {1'b0, lifo_usedw_i};

   assign inflight = {1'b0, occ} + {2'b0, pop_d1};

   // cnt > pop_d1 discounts a pop the stale flags have not seen yet
   assign pop = srst_n_i
             && (state == POP)
             && !abort_i
             && !lifo_wrreq_i
             && !lifo_empty_i
             && (remaining != '0)
             && (cnt > CW'(pop_d1))
             && (inflight <= 3'd1);

   assign lifo_rdreq_o = pop;

   always_comb begin
      cap      = '0;
      cap.data = lifo_q_i;
      cap.sop  = sop_d1;
      cap.eop  = eop_d1 || ((state == POP) && abort_i);
   end

   stream_skid2 #(
      .W (EW)
   ) u_skid (
      .clk_i    (clk_i),
      .srst_n_i (srst_n_i),
      .push_i   (pop_d1),
      .din_i    (cap),
      .ready_i  (ready_i),
      .valid_o  (valid_o),
      .dout_o   (head_w),
      .occ_o    (occ)
   );

   assign head   = skid_entry_t'(head_w);
   assign data_o = head.data;
   assign sop_o  = head.sop;
   // after an abort the sole buffered word is the last one out
   assign eop_o  = head.eop
                || (aborted && !pop_d1 && (occ == 2'd1));

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state     <= IDLE;
         remaining <= '0;
         pop_d1    <= 1'b0;
         sop_d1    <= 1'b0;
         eop_d1    <= 1'b0;
         first_pop <= 1'b0;
         aborted   <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         pop_d1 <= pop;
         sop_d1 <= pop && first_pop;
         eop_d1 <= pop && (remaining == BLEN_W'(1));
         done_o <= 1'b0;
         if (pop) begin
            remaining <= remaining - 1'b1;
            first_pop <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (start_i) begin
                  remaining <= burst_len_i;
                  first_pop <= 1'b1;
                  aborted   <= 1'b0;
                  busy_o    <= 1'b1;
                  if (burst_len_i != '0) begin
                     state <= POP;
                  end else begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end
               end
            end
            POP: begin
               if (abort_i) begin
                  state   <= DRAIN;
                  aborted <= 1'b1;
               end else if (pop && (remaining == BLEN_W'(1))) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!pop_d1 && (occ == 2'd0)) begin
                  state  <= DONE;
                  done_o <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lifo_burst_reader.sv
// Bench for lifo_burst_reader: LIFO model with lagging flags
// plus a scoreboard of expected stream words.
module tb_lifo_burst_reader;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int BW = 4;

   logic          clk;
   logic          srst_n;
   logic          start;
   logic [BW-1:0] blen;
   logic          abort;
   logic          lempty;
   logic          lfull;
   logic [AW-1:0] lusedw;
   logic          wrreq;
   logic [DW-1:0] wdata;
   logic [DW-1:0] lq;
   logic          rdreq;
   logic [DW-1:0] data;
   logic          valid;
   logic          sop;
   logic          eop;
   logic          ready;
   logic          busy;
   logic          done;

   logic          lifo_clr;
   logic [DW-1:0] mem [8];
   int            lcnt;

   logic          ready_main;
   logic          tog_en;
   int            ph;

   typedef struct {
      logic [DW-1:0] d;
      logic          s;
      logic          e;
   } exp_t;

   exp_t sbq[$];

   int total;
   int bad;
   int n_pop;
   int n_acc;
   int n_done;
   logic          prev_stall;
   logic [DW-1:0] prev_data;

   lifo_burst_reader #(
      .DWIDTH     (DW),
      .AWIDTH_EXP (AW),
      .BLEN_W     (BW)
   ) dut (
      .clk_i        (clk),
      .srst_n_i     (srst_n),
      .start_i      (start),
      .burst_len_i  (blen),
      .abort_i      (abort),
      .lifo_empty_i (lempty),
      .lifo_full_i  (lfull),
      .lifo_usedw_i (lusedw),
      .lifo_wrreq_i (wrreq),
      .lifo_q_i     (lq),
      .lifo_rdreq_o (rdreq),
      .data_o       (data),
      .valid_o      (valid),
      .sop_o        (sop),
      .eop_o        (eop),
      .ready_i      (ready),
      .busy_o       (busy),
      .done_o       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // LIFO model: registered q, status flags one cycle behind the count
   always @(posedge clk) begin
      if (lifo_clr) begin
         lcnt <= 0;
      end else if (wrreq && lcnt < 8) begin
         mem[lcnt] <= wdata;
         lcnt      <= lcnt + 1;
      end else if (rdreq && lcnt > 0) begin
         lq   <= mem[lcnt-1];
         lcnt <= lcnt - 1;
      end
      lempty <= (lcnt == 0);
      lfull  <= (lcnt == 8);
      lusedw <= AW'(lcnt);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      wrreq = 1'b1;
      wdata = d;
      tick();
      wrreq = 1'b0;
   endtask

   task automatic expect_word(input logic [DW-1:0] d,
                              input logic s, input logic e);
      exp_t x;
      x.d = d;
      x.s = s;
      x.e = e;
      sbq.push_back(x);
   endtask

   task automatic run_burst(input logic [BW-1:0] len);
      start = 1'b1;
      blen  = len;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      int d0;
      k  = 0;
      d0 = n_done;
      while (n_done == d0 && k < 400) begin
         tick();
         k++;
      end
      repeat (3) tick();
      chk({name, "_done"}, n_done - d0, 1);
      chk({name, "_sb_left"}, sbq.size(), 0);
   endtask

   // ready driver: follows ready_main, or a 1,0,0,1 pattern
   initial begin
      ready = 1'b0;
      ph    = 0;
      forever begin
         @(posedge clk);
         #1;
         ready = tog_en ? ((ph % 4 == 0) || (ph % 4 == 3)) : ready_main;
         ph++;
      end
   end

   // monitor: scoreboard, pop safety, stall hold
   initial begin
      exp_t e;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (srst_n) begin
            if (rdreq) begin
               chk("outstanding", (n_pop + 1 - n_acc) <= 2, 1);
               chk("pop_nonempty", lcnt > 0, 1);
               n_pop++;
            end
            if (wrreq) chk("rd_during_wr", rdreq, 0);
            if (prev_stall) begin
               chk("hold_valid", valid, 1);
               chk("hold_data", data, prev_data);
            end
            if (valid && ready) begin
               n_acc++;
               if (sbq.size() == 0) begin
                  chk("extra_word", data, 9'h100);
               end else begin
                  e = sbq.pop_front();
                  chk("data", data, e.d);
                  chk("sop", sop, e.s);
                  chk("eop", eop, e.e);
               end
            end
            if (done) n_done++;
            prev_stall = valid && !ready;
            prev_data  = data;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      total      = 0;
      bad        = 0;
      n_pop      = 0;
      n_acc      = 0;
      n_done     = 0;
      srst_n     = 1'b0;
      start      = 1'b0;
      blen       = '0;
      abort      = 1'b0;
      wrreq      = 1'b0;
      wdata      = '0;
      ready_main = 1'b0;
      tog_en     = 1'b0;
      lifo_clr   = 1'b1;
      repeat (3) tick();
      chk("rst_outs", {rdreq, valid, sop, eop, busy, done}, 0);
      chk("rst_data", data, 0);
      srst_n     = 1'b1;
      lifo_clr   = 1'b0;
      ready_main = 1'b1;
      tick();

      // 1: basic burst of 4
      push(8'd1); push(8'd2); push(8'd3); push(8'd4);
      repeat (2) tick();
      expect_word(8'd4, 1, 0);
      expect_word(8'd3, 0, 0);
      expect_word(8'd2, 0, 0);
      expect_word(8'd1, 0, 1);
      run_burst(4);
      wait_done("t1");
      chk("t1_lcnt", lcnt, 0);
      chk("t1_empty", lempty, 1);

      // 2: underflow stall, then refill
      push(8'd10); push(8'd11);
      repeat (2) tick();
      expect_word(8'd11, 1, 0);
      expect_word(8'd10, 0, 0);
      expect_word(8'd22, 0, 0);
      expect_word(8'd21, 0, 0);
      expect_word(8'd20, 0, 1);
      p0 = n_pop;
      run_burst(5);
      repeat (20) tick();
      chk("t2_stall_pops", n_pop - p0, 2);
      chk("t2_busy", busy, 1);
      push(8'd20); push(8'd21); push(8'd22);
      wait_done("t2");

      // 3: ready toggling
      push(8'd31); push(8'd32); push(8'd33);
      repeat (2) tick();
      expect_word(8'd33, 1, 0);
      expect_word(8'd32, 0, 0);
      expect_word(8'd31, 0, 1);
      tog_en = 1'b1;
      run_burst(3);
      wait_done("t3");
      tog_en = 1'b0;
      tick();

      // 4: writer holds wrreq during POP
      push(8'd30); push(8'd31);
      repeat (2) tick();
      expect_word(8'd43, 1, 0);
      expect_word(8'd42, 0, 0);
      expect_word(8'd41, 0, 1);
      p0    = n_pop;
      wrreq = 1'b1;
      wdata = 8'd40;
      run_burst(3);
      wdata = 8'd41; tick();
      wdata = 8'd42; tick();
      wdata = 8'd43; tick();
      wrreq = 1'b0;
      chk("t4_no_pop", n_pop - p0, 0);
      wait_done("t4");
      lifo_clr = 1'b1;
      tick();
      lifo_clr = 1'b0;
      repeat (2) tick();

      // 5: full LIFO
      for (int i = 0; i < 8; i++) push(DW'(70 + i));
      repeat (2) tick();
      chk("t5_full", lfull, 1);
      chk("t5_usedw", lusedw, 0);
      for (int i = 7; i >= 0; i--) expect_word(DW'(70 + i), i == 7, i == 0);
      run_burst(8);
      wait_done("t5");
      chk("t5_lcnt", lcnt, 0);
      chk("t5_flags", {lempty, lfull, lusedw}, 5'b10000);

      // 6: abort one cycle after the 2nd pop
      for (int i = 0; i < 6; i++) push(DW'(60 + i));
      repeat (2) tick();
      expect_word(8'd65, 1, 0);
      expect_word(8'd64, 0, 1);
      p0 = n_pop;
      run_burst(6);
      begin
         int k;
         k = 0;
         while (n_pop - p0 < 2 && k < 50) begin
            tick();
            k++;
         end
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done("t6");
      chk("t6_pops", n_pop - p0, 2);

      // reset mid-burst
      ready_main = 1'b0;
      repeat (2) tick();
      p0 = n_done;
      run_burst(3);
      repeat (3) tick();
      chk("mid_busy", busy, 1);
      srst_n = 1'b0;
      tick();
      chk("mrst_outs", {rdreq, valid, sop, eop, busy, done}, 0);
      chk("mrst_data", data, 0);
      srst_n = 1'b1;
      repeat (3) tick();
      chk("mrst_idle", {valid, busy, rdreq}, 0);
      chk("mrst_no_done", n_done - p0, 0);
      chk("final_sb", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
